// File: rtl/io_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// io_input_conditioner_if
// Bundles the raw pin inputs, the sticky-clear controls and the conditioned
// outputs of io_input_conditioner.
//   in_raw        raw asynchronous pin levels
//   in_clear_en   strobe that clears the sticky flags picked by in_clear_mask
//   in_clear_mask per-channel sticky clear select
//   out_port      debounced stable levels (to the I/O block input port)
//   out_rise      one-cycle 0->1 pulse per channel
//   out_fall      one-cycle 1->0 pulse per channel
//   out_sticky    latched rising-edge flags
// Modports: master drives the inputs (pins/CPU side), slave is the conditioner.
// ---------------------------------------------------------------------------
interface io_input_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_raw;
    logic             in_clear_en;
    logic [WIDTH-1:0] in_clear_mask;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] out_rise;
    logic [WIDTH-1:0] out_fall;
    logic [WIDTH-1:0] out_sticky;

    modport master (
        output in_raw,
        output in_clear_en,
        output in_clear_mask,
        input  out_port,
        input  out_rise,
        input  out_fall,
        input  out_sticky
    );

    modport slave (
        input  in_raw,
        input  in_clear_en,
        input  in_clear_mask,
        output out_port,
        output out_rise,
        output out_fall,
        output out_sticky
    );
endinterface

// File: rtl/io_input_conditioner.sv
// ---------------------------------------------------------------------------
// io_input_conditioner
// Synchronises, debounces and edge-detects WIDTH raw input pins before they
// reach the I/O block's memory-mapped input port.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    io_input_conditioner_if.slave (see interface header for signals)
// A new level is accepted only after DEBOUNCE_CYCLES consecutive edges on
// which the synchronised input differs from the current stable level.
// ---------------------------------------------------------------------------
module io_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    io_input_conditioner_if.slave      bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] stable_q;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [WIDTH-1:0] port_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] sticky_q;

    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] clr_sel;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    // port_q still holds the previous stable level, so a difference against
    // stable_q marks the edge at which stable changed.
    assign rise_nxt = stable_q & ~port_q;
    assign clr_sel  = bus.in_clear_en ? bus.in_clear_mask : '0;

    // Metastability synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.in_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Per-channel debounce: count consecutive mismatches, accept on the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_lvl[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= sync_lvl[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Registered outputs: port, edge pulses and sticky flags move together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
        end else begin
            port_q   <= stable_q;
            rise_q   <= rise_nxt;
            fall_q   <= ~stable_q & port_q;
            // A new rise overrides a coincident clear.
            sticky_q <= (sticky_q & ~clr_sel) | rise_nxt;
        end
    end

    assign bus.out_port   = port_q;
    assign bus.out_rise   = rise_q;
    assign bus.out_fall   = fall_q;
    assign bus.out_sticky = sticky_q;
endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Conditions the raw physical input pins before they reach the memory-mapped input port of the I/O block.
- Each channel is synchronised, debounced, and checked for edges.
- out_port drives the I/O block's 4-bit input port directly, so the CPU reads stable, glitch-free levels at the input port address.
- Edge pulses and sticky edge flags are provided for future interrupt and status use.

Parameters:
- WIDTH, 4, number of input channels; equals the I/O block's port width.
- SYNC_STAGES, 2, flip-flops in each metastability synchroniser chain; minimum 2.
- DEBOUNCE_CYCLES, 16, consecutive mismatching clock edges needed to accept a new level; minimum 2. Counter width is clog2(DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_raw  input  WIDTH  asynchronous raw pin levels (buttons/switches).
- in_clear_en  input  1  strobe that clears the sticky flags selected by in_clear_mask.
- in_clear_mask  input  WIDTH  per-channel select for the sticky-flag clear.
- out_port  output  WIDTH  debounced stable level; connects to the I/O block's input port.
- out_rise  output  WIDTH  one-cycle pulse when a channel's stable level goes 0->1.
- out_fall  output  WIDTH  one-cycle pulse when a channel's stable level goes 1->0.
- out_sticky  output  WIDTH  latched rising-edge flags; held until cleared.

Behaviour:
- Reset:
  - rst_n low asynchronously clears the sync chains, stable levels, counters, out_port, out_rise, out_fall and out_sticky to 0.
  - Outputs stay 0 while rst_n is low.
  - Reset asserted mid-debounce discards any partial count.
- Synchroniser: in_raw passes through SYNC_STAGES registers per bit. sync[i] is the last stage.
- Debounce, per channel, evaluated at each rising edge:
  - sync==stable: cnt <= 0.
  - sync!=stable and cnt<DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync!=stable and cnt==DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
- Glitches: any mismatch run shorter than DEBOUNCE_CYCLES consecutive edges leaves stable unchanged and resets the count on the first matching edge.
- Latency:
  - in_raw changes before edge 0 and is held.
  - out_port reflects the new value after edge SYNC_STAGES+DEBOUNCE_CYCLES, i.e. edge 18 with defaults.
  - Channels are independent; simultaneous changes on several channels produce simultaneous updates.
- Edge pulses:
  - out_rise[i] / out_fall[i] are registered.
  - They are high for exactly the one cycle following the edge at which stable[i] changed, aligned with the new out_port value.
  - They are never both high on one channel.
- Sticky flags:
  - out_sticky[i] sets at the same edge that out_rise[i] asserts.
  - out_sticky[i] clears at an edge where in_clear_en=1 and in_clear_mask[i]=1.
  - If set and clear coincide, set wins and the flag stays 1.
  - in_clear_mask is ignored when in_clear_en=0.
- out_port is purely registered; no combinational path from in_raw to any output.

Test Plan:
- Reset: hold rst_n=0 with in_raw=4'b1111 -> all outputs 0. Release rst_n -> out_port=4'b1111 after 18 edges, with out_rise=4'b1111 for one cycle.
- Clean press: in_raw 0000->0100 held -> out_port stays 0000 through edge 17, becomes 0100 after edge 18. out_rise=0100 for exactly one cycle; out_sticky=0100.
- Glitch rejection: in_raw[0] high for 10 edges, then low -> out_port[0], out_rise[0] and out_sticky[0] stay 0 throughout.
- Release and fall: from stable 0100, in_raw=0000 held -> out_port=0000 after 18 edges. out_fall=0100 for one cycle; out_sticky stays 0100.
- Sticky clear race: assert in_clear_en=1, mask=0100 on the same edge a new channel-2 rise is accepted -> out_sticky[2]=1. Repeat the clear on a later edge -> out_sticky=0000.
- Mid-debounce reset: in_raw=1000 for 12 edges, pulse rst_n low, release -> out_port stays 0 until a full 18 edges after release.
